// File: rtl/mem_sweep_pkg.sv
// Shared types and mode-bit positions for the memory sweep controller.
package mem_sweep_pkg;

   // Controller states: sweep issue states, last-compare drain, completion pulse.
   typedef enum logic [2:0] {
      IDLE,
      FILL,
      CHECK,
      DRAIN,
      FIN
   } state_t;

   // Sweep request encodings sampled together with start.
   typedef enum logic [1:0] {
      FILL_CONST  = 2'b00,
      FILL_ADDR   = 2'b01,
      CHECK_CONST = 2'b10,
      CHECK_ADDR  = 2'b11
   } mode_t;

   // mode[1] selects a CHECK sweep, mode[0] selects the address-derived pattern.
   localparam int MODE_CHECK_BIT = 1;
   localparam int MODE_ADDR_BIT  = 0;

endpackage

// File: rtl/mem_sweep_ctrl_if.sv
// Simple-dual-port RAM bus between the sweep controller (master) and the RAM (slave).
interface mem_sweep_ctrl_if #(
   parameter int ADDR_W  = 16,
   parameter int WID_MEM = 1
);

   logic [ADDR_W-1:0]  mem_raddr;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [WID_MEM-1:0] mem_din;
   logic               mem_we;
   logic [WID_MEM-1:0] mem_dout;

   modport master (
      output mem_raddr,
      output mem_waddr,
      output mem_din,
      output mem_we,
      input  mem_dout
   );

   modport slave (
      input  mem_raddr,
      input  mem_waddr,
      input  mem_din,
      input  mem_we,
      output mem_dout
   );

endinterface

// File: rtl/mem_sweep_cmp.sv
// Read-back checker: one-stage issue pipeline, data comparator and the
// saturating mismatch counter with first-failing-address capture.
module mem_sweep_cmp
   import mem_sweep_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int WID_MEM = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               issue,
   input  logic [ADDR_W-1:0]  issue_addr,
   input  logic [WID_MEM-1:0] issue_exp,
   input  logic               kill,
   input  logic [WID_MEM-1:0] rdata,
   output logic [ADDR_W:0]    err_count,
   output logic [ADDR_W-1:0]  first_err_addr
);

   logic               valid_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WID_MEM-1:0] exp_q;
   logic               mismatch;

   // A killed sweep discards whatever read is still in flight.
   assign mismatch = valid_q && !kill && (rdata != exp_q);

   // Track the read issued last cycle so its data can be judged this cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         exp_q   <= '0;
      end else begin
         valid_q <= issue;
         if (issue) begin
            addr_q <= issue_addr;
            exp_q  <= issue_exp;
         end
      end
   end

   // Error accounting: cleared by a new CHECK, first address latched once, count saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (clear) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (mismatch) begin
         if (err_count == '0) begin
            first_err_addr <= addr_q;
         end
         if (err_count != '1) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Memory sweep controller: full-array FILL and CHECK sweeps over one
// simple-dual-port RAM, with user pass-through while idle.
module mem_sweep_ctrl
   import mem_sweep_pkg::*;
#(
   parameter int WID_MEM   = 1,
   parameter int DEPTH_MEM = 65536,
   parameter int ADDR_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [WID_MEM-1:0] pattern,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [ADDR_W:0]    err_count,
   output logic [ADDR_W-1:0]  first_err_addr,
   output logic               err_flag,
   input  logic [ADDR_W-1:0]  usr_raddr,
   input  logic [ADDR_W-1:0]  usr_waddr,
   input  logic [WID_MEM-1:0] usr_din,
   input  logic               usr_we,
   output logic [WID_MEM-1:0] usr_dout,
   output logic               usr_grant,
   mem_sweep_ctrl_if.master   mem
);

   // Terminal address is DEPTH_MEM-1, which need not be all-ones.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
   // Address bits that fit into a data word for the address-derived pattern.
   localparam int EXT_W = (WID_MEM < ADDR_W) ? WID_MEM : ADDR_W;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  cnt_q;
   logic               use_addr_q;
   logic [WID_MEM-1:0] pattern_q;
   logic               aborted_q;

   logic               accept;
   logic               sweeping;
   logic               at_last;
   logic               kill;
   logic               issue;
   logic [WID_MEM-1:0] cnt_data;

   assign accept   = (state_q == IDLE) && start;
   assign sweeping = (state_q == FILL) || (state_q == CHECK) || (state_q == DRAIN);
   assign kill     = sweeping && abort;
   assign at_last  = (cnt_q == LAST_ADDR);
   assign issue    = (state_q == CHECK) && !abort;

   // Pattern word for the current counter address (write data or expected data).
   always_comb begin
      cnt_data = '0;
      if (use_addr_q) begin
         cnt_data[EXT_W-1:0] = cnt_q[EXT_W-1:0];
      end
      cnt_data = cnt_data ^ pattern_q;
   end

   // Next-state logic; start is honoured only in IDLE, abort only while sweeping.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (mode_t'(mode))
                  FILL_CONST, FILL_ADDR: state_d = FILL;
                  default:               state_d = CHECK;
               endcase
            end
         end
         FILL: begin
            if (abort)        state_d = IDLE;
            else if (at_last) state_d = FIN;
         end
         CHECK: begin
            if (abort)        state_d = IDLE;
            else if (at_last) state_d = DRAIN;
         end
         DRAIN:   state_d = abort ? IDLE : FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RAM port mux: user pass-through in IDLE, controller-owned otherwise.
   always_comb begin
      mem.mem_raddr = cnt_q;
      mem.mem_waddr = cnt_q;
      mem.mem_din   = cnt_data;
      mem.mem_we    = 1'b0;
      case (state_q)
         IDLE: begin
            mem.mem_raddr = usr_raddr;
            mem.mem_waddr = usr_waddr;
            mem.mem_din   = usr_din;
            mem.mem_we    = usr_we;
         end
         FILL:    mem.mem_we = 1'b1;
         default: mem.mem_we = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Sweep context: request capture, address counter and sticky abort flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         use_addr_q <= 1'b0;
         pattern_q  <= '0;
         aborted_q  <= 1'b0;
      end else if (accept) begin
         cnt_q      <= '0;
         use_addr_q <= mode[MODE_ADDR_BIT];
         pattern_q  <= pattern;
         aborted_q  <= 1'b0;
      end else begin
         if (kill) begin
            aborted_q <= 1'b1;
         end
         if (((state_q == FILL) || (state_q == CHECK)) && !at_last) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   mem_sweep_cmp #(
      .ADDR_W  (ADDR_W),
      .WID_MEM (WID_MEM)
   ) u_cmp (
      .clk            (clk),
      .reset          (reset),
      .clear          (accept && mode[MODE_CHECK_BIT]),
      .issue          (issue),
      .issue_addr     (cnt_q),
      .issue_exp      (cnt_data),
      .kill           (kill),
      .rdata          (mem.mem_dout),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   assign busy      = sweeping;
   assign done      = (state_q == FIN);
   assign aborted   = aborted_q;
   assign err_flag  = (err_count != '0);
   assign usr_dout  = mem.mem_dout;
   assign usr_grant = ~sweeping;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Self-checking bench for mem_sweep_ctrl with a read-first RAM model and an
// array-level golden image of the expected RAM contents.
module tb_mem_sweep_ctrl;
   import mem_sweep_pkg::*;

   localparam int W = 4;
   localparam int D = 16;
   localparam int A = 4;

   logic           clk;
   logic           reset;
   logic           start;
   logic [1:0]     mode;
   logic [W-1:0]   pattern;
   logic           abort;
   logic           busy;
   logic           done;
   logic           aborted;
   logic [A:0]     err_count;
   logic [A-1:0]   first_err_addr;
   logic           err_flag;
   logic [A-1:0]   usr_raddr;
   logic [A-1:0]   usr_waddr;
   logic [W-1:0]   usr_din;
   logic           usr_we;
   logic [W-1:0]   usr_dout;
   logic           usr_grant;

   logic           bd_we;
   logic [A-1:0]   bd_addr;
   logic [W-1:0]   bd_data;
   logic [W-1:0]   ram  [D];
   logic [W-1:0]   gold [D];

   int n_tests;
   int n_fail;
   int exp_err;
   int exp_first;
   bit exp_aborted;

   mem_sweep_ctrl_if #(.ADDR_W(A), .WID_MEM(W)) mem_bus ();

   mem_sweep_ctrl #(
      .WID_MEM   (W),
      .DEPTH_MEM (D),
      .ADDR_W    (A)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mode           (mode),
      .pattern        (pattern),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .aborted        (aborted),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .err_flag       (err_flag),
      .usr_raddr      (usr_raddr),
      .usr_waddr      (usr_waddr),
      .usr_din        (usr_din),
      .usr_we         (usr_we),
      .usr_dout       (usr_dout),
      .usr_grant      (usr_grant),
      .mem            (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first simple-dual-port RAM with a backdoor write used for corruption.
   always @(posedge clk) begin
      if (bd_we)               ram[bd_addr] <= bd_data;
      else if (mem_bus.mem_we) ram[mem_bus.mem_waddr] <= mem_bus.mem_din;
      mem_bus.mem_dout <= ram[mem_bus.mem_raddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Data word the sweep rules prescribe for address a.
   function automatic logic [W-1:0] ref_word(input bit addr_mode, input logic [W-1:0] pat,
                                             input int a);
      logic [W-1:0] aw;
      aw = W'(a);
      return addr_mode ? (aw ^ pat) : pat;
   endfunction

   task automatic check_status(input string tag);
      check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
      check({tag, "_first_err"}, 32'(first_err_addr), 32'(exp_first));
      check({tag, "_err_flag"}, 32'(err_flag), 32'(exp_err != 0));
      check({tag, "_aborted"}, 32'(aborted), 32'(exp_aborted));
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_grant"}, 32'(usr_grant), 32'd1);
   endtask

   // Read every word back through the idle pass-through port.
   task automatic readback(input string tag);
      for (int a = 0; a < D; a++) begin
         usr_raddr = A'(a);
         tick();
         check($sformatf("%s_rd%0d", tag, a), 32'(usr_dout), 32'(gold[a]));
      end
   endtask

   task automatic corrupt(input int a, input logic [W-1:0] flip);
      bd_we   = 1'b1;
      bd_addr = A'(a);
      bd_data = gold[a] ^ flip;
      tick();
      bd_we   = 1'b0;
      gold[a] = gold[a] ^ flip;
   endtask

   // Run one sweep; optionally abort on a given busy cycle and/or interfere while busy.
   task automatic sweep(input string tag, input logic [1:0] md, input logic [W-1:0] pat,
                        input int abort_at, input bit meddle);
      int busy_n;
      int done_n;
      int done_at;
      int we_bad;
      int n_wr;
      bit ended;
      bit is_check;
      bit addr_mode;
      is_check  = md[MODE_CHECK_BIT];
      addr_mode = md[MODE_ADDR_BIT];
      busy_n = 0; done_n = 0; done_at = 0; we_bad = 0; ended = 0;

      start = 1'b1; mode = md; pattern = pat;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (busy) begin
            busy_n++;
            if (mem_bus.mem_we !== !is_check) we_bad++;
         end
         if (done) begin
            done_n++;
            done_at = c;
         end
         if (!busy && !done) begin
            ended = 1;
            break;
         end
         abort = (busy_n == abort_at) && busy;
         if (meddle && busy) begin
            usr_we    = 1'b1;
            usr_waddr = A'(2);
            usr_din   = ~gold[2];
            start     = (busy_n == 3);
         end else begin
            usr_we = 1'b0;
            start  = 1'b0;
         end
         tick();
      end
      abort = 1'b0; usr_we = 1'b0; start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done) done_n++;
      end

      // Reference model of the sweep's effect.
      if (abort_at > 0) begin
         exp_aborted = 1;
         n_wr = abort_at;
      end else begin
         exp_aborted = 0;
         n_wr = D;
      end
      if (!is_check) begin
         for (int a = 0; a < n_wr; a++) gold[a] = ref_word(addr_mode, pat, a);
      end else begin
         exp_err = 0;
         exp_first = 0;
         for (int a = 0; a < D; a++) begin
            if (gold[a] !== ref_word(addr_mode, pat, a)) begin
               if (exp_err == 0) exp_first = a;
               exp_err++;
            end
         end
         if (exp_err > 31) exp_err = 31;
      end

      check({tag, "_ended"}, 32'(ended), 32'd1);
      check({tag, "_we_cycles_bad"}, 32'(we_bad), 32'd0);
      if (abort_at > 0) begin
         check({tag, "_busy_len"}, 32'(busy_n), 32'(abort_at));
         check({tag, "_done_cnt"}, 32'(done_n), 32'd0);
      end else begin
         check({tag, "_busy_len"}, 32'(busy_n), is_check ? 32'(D + 1) : 32'(D));
         check({tag, "_done_cnt"}, 32'(done_n), 32'd1);
         check({tag, "_done_at"}, 32'(done_at), is_check ? 32'(D + 2) : 32'(D + 1));
      end
      check_status(tag);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      exp_err = 0; exp_first = 0; exp_aborted = 0;
      reset = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; pattern = '0;
      usr_raddr = '0; usr_waddr = '0; usr_din = '0; usr_we = 1'b0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;

      // Reset values.
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_status("rst");
      reset = 1'b1;
      tick();

      // Idle pass-through write then read of address 3.
      usr_we = 1'b1; usr_waddr = A'(3); usr_din = 4'hA;
      #1;
      check("pt_we", 32'(mem_bus.mem_we), 32'd1);
      check("pt_waddr", 32'(mem_bus.mem_waddr), 32'd3);
      check("pt_din", 32'(mem_bus.mem_din), 32'hA);
      tick();
      usr_we = 1'b0; usr_raddr = A'(3);
      tick();
      check("pt_dout", 32'(usr_dout), 32'hA);
      check("pt_grant", 32'(usr_grant), 32'd1);
      gold[3] = 4'hA;

      // FILL_CONST 5 and read back.
      sweep("fill5", 2'b00, 4'h5, 0, 0);
      readback("fill5");

      // FILL_ADDR F then CHECK_ADDR F with user-port interference and a start while busy.
      sweep("filla", 2'b01, 4'hF, 0, 0);
      sweep("chka", 2'b11, 4'hF, 0, 1);
      check("chka_exp_clean", 32'(exp_err), 32'd0);
      readback("chka");

      // Two corrupted words: expect 2 errors, first at 6.
      corrupt(6, 4'h3);
      corrupt(11, 4'h8);
      sweep("chkbad", 2'b11, 4'hF, 0, 0);
      check("chkbad_exp_count", 32'(exp_err), 32'd2);

      // Abort a FILL_CONST 0 on busy cycle 5 over a RAM holding 5.
      sweep("fill5b", 2'b00, 4'h5, 0, 0);
      sweep("abort", 2'b00, 4'h0, 5, 0);
      readback("abort");

      // Randomised rounds; the first start also clears the sticky abort.
      for (int r = 0; r < 6; r++) begin
         int ncor;
         logic [1:0] md;
         logic [W-1:0] pat;
         ncor = $urandom_range(0, 3);
         for (int k = 0; k < ncor; k++) corrupt($urandom_range(0, D - 1), W'($urandom_range(1, 15)));
         md  = 2'($urandom_range(0, 3));
         pat = W'($urandom);
         sweep($sformatf("rnd%0d", r), md, pat, 0, 0);
         readback($sformatf("rnd%0d", r));
      end

      // Reset asserted mid-CHECK after one mismatch has been counted.
      sweep("fill3", 2'b00, 4'h3, 0, 0);
      corrupt(1, 4'h8);
      start = 1'b1; mode = 2'b10; pattern = 4'h3;
      tick();
      start = 1'b0;
      repeat (7) tick();
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_err", 32'(err_count), 32'd1);
      reset = 1'b0;
      #1;
      exp_err = 0; exp_first = 0; exp_aborted = 0;
      check("mrst_done", 32'(done), 32'd0);
      check_status("mrst");
      usr_we = 1'b1; usr_waddr = A'(5); usr_din = 4'h9;
      #1;
      check("mrst_pt_we", 32'(mem_bus.mem_we), 32'd1);
      check("mrst_pt_waddr", 32'(mem_bus.mem_waddr), 32'd5);
      usr_we = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_status("post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
